register_file: RTL

Integer register file for the 64-bit RISC-V core, with a per-register pending-write scoreboard. Decode reads two source operands here and registers each issued destination, while the writeback stage commits results through the single write port. A `hazard_o` stall is raised when a source register has an outstanding write. The block sits between decode/issue, which reads and reserves, and writeback, which writes and releases.

---
 rtl/register_file.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Integer register file for the 64-bit RISC-V core. It has two combinational
// read ports and one write port. Each register also has a pending-write
// scoreboard. Decode reads its operands here and reserves its destination at
// issue. Writeback commits results and releases those reservations.
//
// Parameters
//   DATA_W  register width (default 64)
//   PEND_W  width of each pending counter; up to 2**PEND_W-1 outstanding
//           writes per register
//
// Ports
//   clk              clock, rising edge
//   resetn           asynchronous active-low reset
//   rs1/rs2_addr_i   source indices; reads are combinational
//   rs1/rs2_used_i   the decoding instruction consumes that source
//   rs1/rs2_data_o   source values (x0 always reads 0)
//   hazard_o         a used source has an outstanding write; stall decode
//   issue_valid_i    an instruction with a destination issues this cycle
//   issue_rd_addr_i  destination index of the issuing instruction
//   issue_ready_o    destination counter not saturated (issue accepted when
//                    issue_valid_i && issue_ready_o)
//   rf_wr_en_i       writeback commit strobe
//   rf_wr_addr_i     writeback destination index
//   rf_wr_data_i     writeback data
//
// Configuration macro
//   RF_BYPASS_EN  when defined, a same-cycle writeback is forwarded to the read
//                 ports. The hazard term of that source is dropped when this
//                 write is its last outstanding one.
// -----------------------------------------------------------------------------
module register_file #(
   parameter int DATA_W = 64,
   parameter int PEND_W = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [4:0]        rs1_addr_i,
   input  logic [4:0]        rs2_addr_i,
   input  logic              rs1_used_i,
   input  logic              rs2_used_i,
   output logic [DATA_W-1:0] rs1_data_o,
   output logic [DATA_W-1:0] rs2_data_o,
   output logic              hazard_o,
   input  logic              issue_valid_i,
   input  logic [4:0]        issue_rd_addr_i,
   output logic              issue_ready_o,
   input  logic              rf_wr_en_i,
   input  logic [4:0]        rf_wr_addr_i,
   input  logic [DATA_W-1:0] rf_wr_data_i
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

   // Entry 0 of both arrays is cleared at reset and never written again, so
   // x0 reads 0 and never looks pending.
   logic [DATA_W-1:0] r_regs [32];
   logic [PEND_W-1:0] r_pend [32];

   logic              w_issue_acc;
   logic [31:0]       w_inc;
   logic [31:0]       w_dec;
   logic [PEND_W-1:0] w_rs1_pend;
   logic [PEND_W-1:0] w_rs2_pend;
   logic              w_rs1_byp;
   logic              w_rs2_byp;
   logic              w_rs1_haz;
   logic              w_rs2_haz;

   // ---------------------------------------------------------------------------
   // Issue acceptance. The check uses only the registered count. A release of
   // the same register in this cycle does not raise ready until the next cycle.
   // ---------------------------------------------------------------------------
   assign issue_ready_o = !((issue_rd_addr_i != 5'd0) &&
                            (r_pend[issue_rd_addr_i] == PEND_MAX));
   assign w_issue_acc   = issue_valid_i && issue_ready_o;

   // One-hot increment and decrement requests per register.
   // NOTE: give every always_comb output a default first, so that no path can
   // leave an output unassigned and infer a latch.
   always_comb begin
      w_inc = '0;
      w_dec = '0;
      if (w_issue_acc && (issue_rd_addr_i != 5'd0)) begin
         w_inc[issue_rd_addr_i] = 1'b1;
      end
      if (rf_wr_en_i && (rf_wr_addr_i != 5'd0)) begin
         w_dec[rf_wr_addr_i] = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Register storage
   // ---------------------------------------------------------------------------
   // NOTE: this array is reset on purpose, because architectural state must
   // read 0 after reset. That costs a flop-based array rather than an SRAM
   // macro, which is acceptable for 31 entries.
   // NOTE: sequential state takes non-blocking assignments only, so every
   // flop samples the values from before the edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= '0;
         end
      end else if (rf_wr_en_i && (rf_wr_addr_i != 5'd0)) begin
         r_regs[rf_wr_addr_i] <= rf_wr_data_i;
      end
   end

   // ---------------------------------------------------------------------------
   // Pending-write counters. An issue and a release in the same cycle cancel
   // out. A release on an idle counter is a protocol error: it is ignored, so
   // the count cannot underflow.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 32; i++) begin
            r_pend[i] <= '0;
         end
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (w_inc[i] && !w_dec[i]) begin
               r_pend[i] <= r_pend[i] + PEND_ONE;
            end else if (w_dec[i] && !w_inc[i] && (r_pend[i] != '0)) begin
               r_pend[i] <= r_pend[i] - PEND_ONE;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read ports and hazard detection
   // ---------------------------------------------------------------------------
   assign w_rs1_pend = r_pend[rs1_addr_i];
   assign w_rs2_pend = r_pend[rs2_addr_i];

`ifdef RF_BYPASS_EN
   assign w_rs1_byp = rf_wr_en_i && (rf_wr_addr_i == rs1_addr_i) && (rs1_addr_i != 5'd0);
   assign w_rs2_byp = rf_wr_en_i && (rf_wr_addr_i == rs2_addr_i) && (rs2_addr_i != 5'd0);
`else
   assign w_rs1_byp = 1'b0;
   assign w_rs2_byp = 1'b0;
`endif

   assign rs1_data_o = w_rs1_byp             ? rf_wr_data_i :
                       (rs1_addr_i == 5'd0)  ? '0 : r_regs[rs1_addr_i];
   assign rs2_data_o = w_rs2_byp             ? rf_wr_data_i :
                       (rs2_addr_i == 5'd0)  ? '0 : r_regs[rs2_addr_i];

   // A forwarded write that is the only outstanding one clears that hazard.
   assign w_rs1_haz = rs1_used_i && (rs1_addr_i != 5'd0) && (w_rs1_pend != '0) &&
                      !(w_rs1_byp && (w_rs1_pend == PEND_ONE));
   assign w_rs2_haz = rs2_used_i && (rs2_addr_i != 5'd0) && (w_rs2_pend != '0) &&
                      !(w_rs2_byp && (w_rs2_pend == PEND_ONE));

   assign hazard_o = w_rs1_haz || w_rs2_haz;

endmodule
